selfcheck_monitor: RTL
======================

# selfcheck_monitor

Synthesizable self-check monitor that sits directly downstream of the MIPS `top` data-memory write port. It snoops every store (`memwrite`, `dataadr`, `writedata`), latches PASS when a store matches one of the known test-program completion signatures, and latches FAIL on a cycle-count watchdog. It also keeps a small trace FIFO of stores, so a board UART/LED driver can report results without a simulator.

## Interface
- `TIMEOUT`, 580: cycle budget in RUN before FAIL.
- `TRACE_DEPTH`, 8: store-trace FIFO entries; power of two, ≥2.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `memwrite`  in  2: store strobe from `top`; any nonzero value is a store.
- `dataadr`  in  64: store byte address.
- `writedata`  in  64: store data.
- `status`  out  2: 0 RUN, 1 PASS, 2 FAIL; 3 is never driven.
- `test_id`  out  3: matched signature ID. 0 means none.
- `cycles`  out  32: RUN cycles elapsed; frozen after PASS/FAIL.
- `trace_rd`  in  1: pop the trace head.
- `trace_valid`  out  1: FIFO not empty.
- `trace_adr`  out  64: head entry address.
- `trace_data`  out  64: head entry data.
- `trace_overflow`  out  1: sticky; a store was dropped.

## Operation
- FSM states: RUN, PASS, FAIL. Reset enters RUN.
- PASS and FAIL are terminal; only `reset` leaves them.
- In RUN, a store compares (`dataadr`, `writedata`) against the signatures using full 64-bit equality:
  - (100, 7): ID 1, standard2
  - (508, 7): ID 2, power2
  - (80, 1): ID 3, loadstore
  - (320, 4950): ID 4, more
- On a match: go to PASS and latch the ID. Signatures are mutually exclusive by address.
- In RUN, `cycles` increments every cycle. If `cycles` would reach `TIMEOUT` with no match that cycle, go to FAIL with `test_id`=0.
- Simultaneous match and timeout: PASS wins.
- Every store accepted in RUN is pushed to the trace, including the matching store. Stores in PASS/FAIL are not traced.
- Trace is first-word-fall-through; head is valid whenever `trace_valid`=1.
- `trace_rd` while empty is ignored.
- Push while full with no pop: drop the new entry and set `trace_overflow`.
- Push and pop in the same cycle when full: both take effect; no overflow.
- Push and pop in the same cycle when empty: the entry is stored and the pop is ignored.
- Trace reads stay allowed in PASS/FAIL.

## Timing
- All outputs registered. Reset values:
  - `status`=0, `test_id`=0, `cycles`=0
  - `trace_valid`=0, `trace_adr`=0, `trace_data`=0, `trace_overflow`=0
- A matching store sampled at edge N shows `status`=1 and the ID after edge N.
- `cycles` reads k after k edges following reset release. FAIL is visible after the edge on which `cycles` becomes `TIMEOUT`, and `cycles` holds at `TIMEOUT`.
- Trace push at edge N: `trace_valid`=1 after edge N.
- Pop at edge N: the next head (or `trace_valid`=0) appears after edge N.
- Reset asserted mid-run, with PASS/FAIL latched, or with a non-empty FIFO: at the next edge, all state returns to reset values and the FIFO is emptied.

## Structure
- Package `mips_sim_pkg`: status enum (`ST_RUN`, `ST_PASS`, `ST_FAIL`), signature address/data constants, and the ID constants.
- Sub-module `trace_fifo` (params `DEPTH`, `W`=128): count-based full/empty, wrapping read/write pointers, sticky overflow.
- Top level: FSM, comparators, counter.

## Test plan
- Stores (40,3), (44,5), then (100,7) at cycle 30 → `status`=1 and `test_id`=1 at cycle 31. The trace holds all three entries in order and `cycles` freezes at 31.
- Store (320,4950) → `test_id`=4. A later store (100,7) leaves `test_id`=4 and is not traced.
- No stores → `status`=2 right after the edge where `cycles`=580; `test_id`=0 and `cycles` stays 580.
- Store (508,7) on the same edge the counter reaches 580 → `status`=1, `test_id`=2.
- 10 stores with no reads, depth 8 → 8 entries retained (the first 8), `trace_overflow`=1. Popping 8 times returns them in order, then `trace_valid`=0.
- Full FIFO with push and pop together → count stays 8 and `trace_overflow` stays 0.
- `reset` pulsed while in PASS with 3 entries queued → after the next edge all outputs are 0 and `status`=RUN.

Source files
------------

// File: rtl/mips_sim_pkg.sv
// Shared definitions for the MIPS self-check monitor.
//   status_e    : monitor verdict encoding as seen on the status port
//   SIG_*       : (address, data) completion signatures of the known test programs
//   ID_*        : signature identifiers reported on test_id (ID_NONE = no match)
//   sig_match() : returns the ID of the signature a store matches, or ID_NONE
package mips_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } status_e;

    localparam logic [63:0] SIG_STANDARD2_ADR  = 64'd100;
    localparam logic [63:0] SIG_STANDARD2_DATA = 64'd7;
    localparam logic [63:0] SIG_POWER2_ADR     = 64'd508;
    localparam logic [63:0] SIG_POWER2_DATA    = 64'd7;
    localparam logic [63:0] SIG_LOADSTORE_ADR  = 64'd80;
    localparam logic [63:0] SIG_LOADSTORE_DATA = 64'd1;
    localparam logic [63:0] SIG_MORE_ADR       = 64'd320;
    localparam logic [63:0] SIG_MORE_DATA      = 64'd4950;

    localparam logic [2:0] ID_NONE      = 3'd0;
    localparam logic [2:0] ID_STANDARD2 = 3'd1;
    localparam logic [2:0] ID_POWER2    = 3'd2;
    localparam logic [2:0] ID_LOADSTORE = 3'd3;
    localparam logic [2:0] ID_MORE      = 3'd4;

    // Signature addresses are all distinct, so at most one branch can hit.
    function automatic logic [2:0] sig_match(input logic [63:0] adr,
                                             input logic [63:0] data);
        logic [2:0] id;
        id = ID_NONE;
        if (adr == SIG_STANDARD2_ADR && data == SIG_STANDARD2_DATA) id = ID_STANDARD2;
        if (adr == SIG_POWER2_ADR    && data == SIG_POWER2_DATA)    id = ID_POWER2;
        if (adr == SIG_LOADSTORE_ADR && data == SIG_LOADSTORE_DATA) id = ID_LOADSTORE;
        if (adr == SIG_MORE_ADR      && data == SIG_MORE_DATA)      id = ID_MORE;
        return id;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through store-trace FIFO with a registered head.
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write request and entry
//   pop        : remove the head (ignored while empty)
//   valid      : FIFO not empty (registered)
//   dout       : head entry (registered, valid whenever valid=1)
//   overflow   : sticky; set when a push was dropped because the FIFO was full
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;

    logic empty, full, pop_eff, push_eff;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_eff  = pop && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push_eff = push && (!full || pop_eff);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push_eff && !pop_eff) count_d = count_q + 1'b1;
        if (!push_eff && pop_eff) count_d = count_q - 1'b1;

        overflow_d = overflow_q || (push && !push_eff);
        valid_d    = (count_d != '0);

        // The new head lives in memory unless it is the entry being written
        // this very cycle (push into empty, or push+pop with one entry).
        head_d = head_q;
        if (count_d != '0) begin
            if (push_eff && (rd_ptr_d == wr_ptr_q)) head_d = din;
            else                                    head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid    = valid_q;
    assign dout     = head_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/selfcheck_monitor.sv
// Self-check monitor snooping the MIPS data-memory write port.
//   clk, reset          : clock and synchronous active-high reset
//   memwrite            : store strobe (any nonzero value is a store)
//   dataadr, writedata  : store address and data
//   status              : 0 RUN, 1 PASS, 2 FAIL (terminal until reset)
//   test_id             : ID of the matched completion signature, 0 if none
//   cycles              : cycles spent in RUN, frozen once a verdict is latched
//   trace_rd            : pop the trace head
//   trace_valid/adr/data: FWFT head of the store trace
//   trace_overflow      : sticky, a store was dropped from the trace
module selfcheck_monitor
    import mips_sim_pkg::*;
#(
    parameter int TIMEOUT     = 580,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memwrite,
    input  logic [63:0] dataadr,
    input  logic [63:0] writedata,
    output logic [1:0]  status,
    output logic [2:0]  test_id,
    output logic [31:0] cycles,
    input  logic        trace_rd,
    output logic        trace_valid,
    output logic [63:0] trace_adr,
    output logic [63:0] trace_data,
    output logic        trace_overflow
);
    status_e     state_q, state_d;
    logic [2:0]  test_id_q, test_id_d;
    logic [31:0] cycles_q, cycles_d;

    logic        store;
    logic [2:0]  match_id;
    logic        push;
    logic [127:0] trace_head;

    always_comb begin
        store    = (memwrite != 2'b00);
        match_id = store ? sig_match(dataadr, writedata) : ID_NONE;

        state_d   = state_q;
        test_id_d = test_id_q;
        cycles_d  = cycles_q;
        push      = 1'b0;

        case (state_q)
            ST_RUN: begin
                push     = store;
                cycles_d = cycles_q + 32'd1;
                // A match on the timeout cycle still counts as a pass.
                if (match_id != ID_NONE) begin
                    state_d   = ST_PASS;
                    test_id_d = match_id;
                end else if (cycles_d == 32'(TIMEOUT)) begin
                    state_d = ST_FAIL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            test_id_q <= ID_NONE;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            test_id_q <= test_id_d;
            cycles_q  <= cycles_d;
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (128)
    ) u_trace (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      ({dataadr, writedata}),
        .pop      (trace_rd),
        .valid    (trace_valid),
        .dout     (trace_head),
        .overflow (trace_overflow)
    );

    assign status     = state_q;
    assign test_id    = test_id_q;
    assign cycles     = cycles_q;
    assign trace_adr  = trace_head[127:64];
    assign trace_data = trace_head[63:0];

endmodule
